// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, single-outstanding imem request FSM and IF/ID register.
// Define FETCH_PERF_CNT_EN to add the fetch_count / squash_count performance counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall_F,
    input  logic        pc_src,
    input  logic [31:0] jump_address,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_data,
    output logic [31:0] instruction,
    output logic [31:0] pc_plus_four,
    output logic        instr_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] squash_count
`endif
);

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc_F;
    logic [31:0] pc_next;
    logic [31:0] hold_word;
    logic [31:0] hold_next;
    logic [31:0] deliver_word;
    logic        redirect;
    logic        deliver;

    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    // A stalled decode cannot redirect; pc_src is only honoured when the stage moves.
    assign redirect  = pc_src & ~stall_F;
    assign imem_addr = pc_F;

    always_comb begin
        state_next   = state;
        pc_next      = pc_F;
        hold_next    = hold_word;
        deliver      = 1'b0;
        deliver_word = imem_data;
        imem_req     = 1'b0;

        case (state)
            ISSUE: begin
                if (redirect) begin
                    pc_next = jump_address;
                end else begin
                    imem_req   = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    pc_next    = jump_address;
                    state_next = imem_valid ? ISSUE : DRAIN;
                end else if (imem_valid) begin
                    if (stall_F) begin
                        hold_next  = imem_data;
                        state_next = HOLD;
                    end else begin
                        deliver    = 1'b1;
                        pc_next    = pc_inc(pc_F);
                        state_next = ISSUE;
                    end
                end
            end
            HOLD: begin
                deliver_word = hold_word;
                if (redirect) begin
                    pc_next    = jump_address;
                    state_next = ISSUE;
                end else if (!stall_F) begin
                    deliver    = 1'b1;
                    pc_next    = pc_inc(pc_F);
                    state_next = ISSUE;
                end
            end
            DRAIN: begin
                // The response still in flight belongs to the abandoned path.
                if (redirect) begin
                    pc_next = jump_address;
                end
                if (imem_valid) begin
                    state_next = ISSUE;
                end
            end
            default: begin
                state_next = ISSUE;
            end
        endcase

        if (reset) begin
            imem_req = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ISSUE;
            pc_F      <= RESET_PC;
            hold_word <= 32'd0;
        end else begin
            state     <= state_next;
            pc_F      <= pc_next;
            hold_word <= hold_next;
        end
    end

    // IF/ID register: stall freezes it, a redirect flushes it, otherwise it takes a word or a bubble.
    always_ff @(posedge clock) begin
        if (reset) begin
            instruction  <= NOP_WORD;
            pc_plus_four <= 32'd0;
            instr_valid  <= 1'b0;
        end else if (!stall_F) begin
            if (deliver) begin
                instruction  <= deliver_word;
                pc_plus_four <= pc_inc(pc_F);
                instr_valid  <= 1'b1;
            end else begin
                instruction  <= NOP_WORD;
                instr_valid  <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic discard_resp;
    logic flush_valid;

    always_comb begin
        discard_resp = 1'b0;
        case (state)
            WAIT:    discard_resp = redirect & imem_valid;
            HOLD:    discard_resp = redirect;
            DRAIN:   discard_resp = imem_valid;
            default: discard_resp = 1'b0;
        endcase
    end

    assign flush_valid = redirect & instr_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_count  <= 32'd0;
            squash_count <= 32'd0;
        end else begin
            fetch_count  <= fetch_count + {31'd0, deliver};
            squash_count <= squash_count + {31'd0, discard_resp} + {31'd0, flush_valid};
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized run against a flag-based model.
module tb_fetch_stage;

    localparam logic [31:0] RPC = 32'h0040_0000;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall_F;
    logic        pc_src;
    logic [31:0] jump_address;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_data;
    logic [31:0] instruction;
    logic [31:0] pc_plus_four;
    logic        instr_valid;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    fetch_stage dut (
        .clock        (clock),
        .reset        (reset),
        .stall_F      (stall_F),
        .pc_src       (pc_src),
        .jump_address (jump_address),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_valid   (imem_valid),
        .imem_data    (imem_data),
        .instruction  (instruction),
        .pc_plus_four (pc_plus_four),
        .instr_valid  (instr_valid)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        stall_F      = 1'b0;
        pc_src       = 1'b0;
        jump_address = 32'd0;
        imem_valid   = 1'b0;
        imem_data    = 32'd0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        // one fetch so that IF/ID holds a real word before the next reset
        tick();
        imem_valid = 1'b1; imem_data = 32'hDEAD_BEEF;
        tick();
        idle_inputs();
        reset = 1'b1; imem_valid = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b want 0", imem_req); end
        tick();
        checks++; if (instruction !== NOP) begin errors++; $display("FAIL reset_instr: got %h want %h", instruction, NOP); end
        checks++; if (pc_plus_four !== 32'd0) begin errors++; $display("FAIL reset_ppf: got %h want 0", pc_plus_four); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_vld: got %0b want 0", instr_valid); end
        reset = 1'b0; imem_valid = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL reset_first_req: got %0b want 1", imem_req); end
        checks++; if (imem_addr !== RPC) begin errors++; $display("FAIL reset_first_addr: got %h want %h", imem_addr, RPC); end
    endtask

    task automatic test_basic();
        apply_reset();
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0000) begin errors++; $display("FAIL basic_issue: got req=%0b addr=%h want 1 00400000", imem_req, imem_addr); end
        tick();
        imem_valid = 1'b1; imem_data = 32'h2008_0005;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL basic_wait_req: got %0b want 0", imem_req); end
        tick();
        checks++; if (instruction !== 32'h2008_0005) begin errors++; $display("FAIL basic_instr: got %h want 20080005", instruction); end
        checks++; if (pc_plus_four !== 32'h0040_0004) begin errors++; $display("FAIL basic_ppf: got %h want 00400004", pc_plus_four); end
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL basic_vld: got %0b want 1", instr_valid); end
        imem_valid = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0004) begin errors++; $display("FAIL basic_next_addr: got req=%0b addr=%h want 1 00400004", imem_req, imem_addr); end
        tick();
        checks++; if (instr_valid !== 1'b0 || instruction !== NOP) begin errors++; $display("FAIL basic_bubble: got vld=%0b instr=%h want 0 %h", instr_valid, instruction, NOP); end
    endtask

    task automatic test_stall_hold();
        apply_reset();
        tick();
        imem_valid = 1'b1; imem_data = 32'h1111_AAAA;
        tick();
        imem_valid = 1'b0; stall_F = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0004) begin errors++; $display("FAIL hold_issue: got req=%0b addr=%h want 1 00400004", imem_req, imem_addr); end
        tick();
        imem_valid = 1'b1; imem_data = 32'h2222_BBBB;
        tick();
        checks++; if (instruction !== 32'h1111_AAAA || instr_valid !== 1'b1) begin errors++; $display("FAIL hold_frozen1: got %h/%0b want 1111aaaa/1", instruction, instr_valid); end
        imem_valid = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hold_no_req: got %0b want 0", imem_req); end
        tick();
        checks++; if (instruction !== 32'h1111_AAAA || pc_plus_four !== 32'h0040_0004) begin errors++; $display("FAIL hold_frozen2: got %h/%h want 1111aaaa/00400004", instruction, pc_plus_four); end
        stall_F = 1'b0;
        tick();
        checks++; if (instruction !== 32'h2222_BBBB) begin errors++; $display("FAIL hold_release_instr: got %h want 2222bbbb", instruction); end
        checks++; if (pc_plus_four !== 32'h0040_0008 || instr_valid !== 1'b1) begin errors++; $display("FAIL hold_release_ppf: got %h/%0b want 00400008/1", pc_plus_four, instr_valid); end
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0008) begin errors++; $display("FAIL hold_next_addr: got req=%0b addr=%h want 1 00400008", imem_req, imem_addr); end
    endtask

    task automatic test_redirect_drain();
        apply_reset();
        tick();
        imem_valid = 1'b1; imem_data = 32'h3333_CCCC;
        tick();
        imem_valid = 1'b0;
        tick();
        pc_src = 1'b1; jump_address = 32'h0040_0100;
        tick();
        checks++; if (instr_valid !== 1'b0 || instruction !== NOP) begin errors++; $display("FAIL drain_flush: got vld=%0b instr=%h want 0 %h", instr_valid, instruction, NOP); end
        checks++; if (pc_plus_four !== 32'h0040_0004) begin errors++; $display("FAIL drain_ppf_kept: got %h want 00400004", pc_plus_four); end
        pc_src = 1'b0; jump_address = 32'd0;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL drain_no_req1: got %0b want 0", imem_req); end
        tick();
        imem_valid = 1'b1; imem_data = 32'h5757_5757;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL drain_no_req2: got %0b want 0", imem_req); end
        tick();
        checks++; if (instr_valid !== 1'b0 || instruction !== NOP) begin errors++; $display("FAIL drain_stale: got vld=%0b instr=%h want 0 %h", instr_valid, instruction, NOP); end
        imem_valid = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0100) begin errors++; $display("FAIL drain_target: got req=%0b addr=%h want 1 00400100", imem_req, imem_addr); end
    endtask

    task automatic test_stall_redirect();
        apply_reset();
        stall_F = 1'b1; pc_src = 1'b1; jump_address = 32'h1234_5678;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== RPC) begin errors++; $display("FAIL stallredir_issue: got req=%0b addr=%h want 1 %h", imem_req, imem_addr, RPC); end
        tick();
        imem_valid = 1'b1; imem_data = 32'h4444_DDDD;
        tick();
        imem_valid = 1'b0; stall_F = 1'b0; pc_src = 1'b0;
        tick();
        checks++; if (instruction !== 32'h4444_DDDD || pc_plus_four !== 32'h0040_0004) begin errors++; $display("FAIL stallredir_word: got %h/%h want 4444dddd/00400004", instruction, pc_plus_four); end
        #1;
        checks++; if (imem_addr !== 32'h0040_0004) begin errors++; $display("FAIL stallredir_pc: got %h want 00400004", imem_addr); end
    endtask

    task automatic test_wrap();
        apply_reset();
        pc_src = 1'b1; jump_address = 32'hFFFF_FFFC;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL wrap_redir_req: got %0b want 0", imem_req); end
        tick();
        pc_src = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_issue: got req=%0b addr=%h want 1 fffffffc", imem_req, imem_addr); end
        tick();
        imem_valid = 1'b1; imem_data = 32'h6666_EEEE;
        tick();
        checks++; if (pc_plus_four !== 32'd0 || instruction !== 32'h6666_EEEE || instr_valid !== 1'b1) begin errors++; $display("FAIL wrap_ppf: got %h/%h/%0b want 0/6666eeee/1", pc_plus_four, instruction, instr_valid); end
        imem_valid = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin errors++; $display("FAIL wrap_next: got req=%0b addr=%h want 1 0", imem_req, imem_addr); end
    endtask

    task automatic test_reset_in_wait();
        apply_reset();
        tick();
        reset = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rstwait_req: got %0b want 0", imem_req); end
        tick();
        reset = 1'b0; imem_valid = 1'b1; imem_data = 32'h7777_1234;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== RPC) begin errors++; $display("FAIL rstwait_issue: got req=%0b addr=%h want 1 %h", imem_req, imem_addr, RPC); end
        tick();
        checks++; if (instr_valid !== 1'b0 || instruction !== NOP) begin errors++; $display("FAIL rstwait_ignored: got vld=%0b instr=%h want 0 %h", instr_valid, instruction, NOP); end
        imem_valid = 1'b1; imem_data = 32'h8888_0001;
        tick();
        checks++; if (instruction !== 32'h8888_0001 || pc_plus_four !== RPC + 32'd4) begin errors++; $display("FAIL rstwait_fetch: got %h/%h want 88880001/%h", instruction, pc_plus_four, RPC + 32'd4); end
        imem_valid = 1'b0;
    endtask

    // Reference: a request is either pending (to deliver), draining (to drop), or its word is parked.
    task automatic test_random();
        logic [31:0] m_pc, m_instr, m_ppf, m_hword;
        logic        m_vld;
        bit          m_pend, m_drain, m_held;
        int          mem_due;
        apply_reset();
        m_pc = RPC; m_instr = NOP; m_ppf = 32'd0; m_vld = 1'b0; m_hword = 32'd0;
        m_pend = 0; m_drain = 0; m_held = 0; mem_due = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            bit          redir, exp_req, give;
            logic [31:0] word;
            stall_F      = ($urandom % 4) == 0;
            pc_src       = ($urandom % 6) == 0;
            jump_address = (($urandom % 8) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            imem_valid   = (mem_due == 1);
            if (mem_due > 0) mem_due--;
            if (!m_pend && !m_drain && mem_due == 0 && ($urandom % 10) == 0) imem_valid = 1'b1;
            imem_data    = $urandom;
            #1;
            redir   = pc_src && !stall_F;
            exp_req = !m_pend && !m_drain && !m_held && !redir;
            checks++; if (imem_req !== exp_req) begin errors++; $display("FAIL rand_req c%0d: got %0b want %0b", cyc, imem_req, exp_req); end
            if (exp_req) begin
                checks++; if (imem_addr !== m_pc) begin errors++; $display("FAIL rand_addr c%0d: got %h want %h", cyc, imem_addr, m_pc); end
                mem_due = $urandom_range(1, 3);
            end
            give = 0; word = 32'd0;
            if (m_pend) begin
                if (redir) begin
                    m_pend = 0; m_drain = !imem_valid; m_pc = jump_address;
                end else if (imem_valid) begin
                    m_pend = 0;
                    if (stall_F) begin m_held = 1; m_hword = imem_data; end
                    else begin give = 1; word = imem_data; end
                end
            end else if (m_held) begin
                if (redir) begin m_held = 0; m_pc = jump_address; end
                else if (!stall_F) begin m_held = 0; give = 1; word = m_hword; end
            end else if (m_drain) begin
                if (redir) m_pc = jump_address;
                if (imem_valid) m_drain = 0;
            end else begin
                if (redir) m_pc = jump_address;
                else m_pend = 1;
            end
            if (!stall_F) begin
                if (give) begin m_instr = word; m_ppf = m_pc + 32'd4; m_vld = 1'b1; m_pc = m_pc + 32'd4; end
                else begin m_instr = NOP; m_vld = 1'b0; end
            end
            tick();
            checks++;
            if (instruction !== m_instr || pc_plus_four !== m_ppf || instr_valid !== m_vld) begin
                errors++;
                $display("FAIL rand_ifid c%0d: got %h/%h/%0b want %h/%h/%0b", cyc, instruction, pc_plus_four, instr_valid, m_instr, m_ppf, m_vld);
            end
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_basic();
        test_stall_hold();
        test_redirect_drain();
        test_stall_redirect();
        test_wrap();
        test_reset_in_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0040_0000, PC loaded on reset.
REQ-002 Parameter NOP_WORD, default 32'h0000_0000, instruction presented to decode during a bubble.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall_F  input  1  hazard-unit stall: hold the PC and the IF/ID register.
REQ-006 pc_src  input  1  decode-stage redirect request.
REQ-007 jump_address  input  32  redirect target from decode.
REQ-008 imem_req  output  1  single-cycle instruction-memory read request.
REQ-009 imem_addr  output  32  read address, valid while imem_req=1.
REQ-010 imem_valid  input  1  read-data strobe, at least 1 cycle after imem_req.
REQ-011 imem_data  input  32  read data, valid while imem_valid=1.
REQ-012 instruction  output  32  IF/ID instruction register to decode.
REQ-013 pc_plus_four  output  32  IF/ID address of the fetched word plus 4.
REQ-014 instr_valid  output  1  IF/ID entry holds a real instruction, not a bubble.

Function
REQ-015 The PC register is pc_F; at most one memory request is outstanding.
REQ-016 The FSM has four states: ISSUE, WAIT, HOLD and DRAIN.
REQ-017 A redirect is pc_src=1 and stall_F=0; pc_src is ignored while stall_F=1.
REQ-018 ISSUE without a redirect: imem_req=1 and imem_addr=pc_F (combinational), then go to WAIT.
REQ-019 ISSUE with a redirect: imem_req=0 and pc_F<=jump_address; stay in ISSUE.
REQ-020 WAIT with imem_valid=1, stall_F=0 and no redirect: load instruction<=imem_data, pc_plus_four<=pc_F+4 and instr_valid<=1; set pc_F<=pc_F+4; go to ISSUE.
REQ-021 WAIT with imem_valid=1 and stall_F=1: capture imem_data in the hold register and go to HOLD. The IF/ID register and pc_F are unchanged.
REQ-022 HOLD with stall_F=0 and no redirect: load IF/ID from the hold register, set pc_F<=pc_F+4 and go to ISSUE.
REQ-023 WAIT with a redirect and imem_valid=0: set pc_F<=jump_address and go to DRAIN.
REQ-024 WAIT with a redirect and imem_valid=1: discard the data, set pc_F<=jump_address and go to ISSUE.
REQ-025 HOLD with a redirect: discard the hold register, set pc_F<=jump_address and go to ISSUE.
REQ-026 DRAIN: imem_req=0; on imem_valid=1, discard the data and go to ISSUE. A further redirect while in DRAIN updates pc_F.
REQ-027 A redirect in any state flushes IF/ID on the same edge: instruction<=NOP_WORD, instr_valid<=0, pc_plus_four unchanged.
REQ-028 stall_F=1 holds instruction, pc_plus_four and instr_valid unchanged in every state.
REQ-029 In any cycle with stall_F=0, no redirect and no delivery to IF/ID, IF/ID loads a bubble: NOP_WORD, instr_valid=0.
REQ-030 Arithmetic is 32-bit unsigned and pc_F+4 wraps modulo 2^32. jump_address is used unmodified; no alignment check.
REQ-031 Best-case throughput is one instruction per two cycles (ISSUE, then WAIT with a 1-cycle memory).
REQ-032 imem_valid in ISSUE or HOLD is a protocol violation; it is ignored.

Reset
REQ-033 While reset=1: state<=ISSUE, pc_F<=RESET_PC, instruction<=NOP_WORD, pc_plus_four<=0, instr_valid<=0, hold register<=0, imem_req=0.
REQ-034 reset=1 takes priority over all other inputs. Reset during WAIT abandons the request; a later imem_valid is handled per REQ-032.
REQ-035 The first imem_req, with address RESET_PC, is issued in the first cycle after reset deasserts.

Configuration
REQ-036 The macro FETCH_PERF_CNT_EN selects the performance counters.
REQ-037 With FETCH_PERF_CNT_EN defined, two outputs are added: fetch_count (32) counts IF/ID loads with instr_valid=1, and squash_count (32) counts discarded responses and flushed valid IF/ID entries. Both reset to 0 and wrap.
REQ-038 Without FETCH_PERF_CNT_EN, neither port nor counter exists and behaviour is otherwise identical.

Verification
REQ-039 Reset, then a 1-cycle memory returning 32'h2008_0005: imem_addr=32'h0040_0000, then instruction=32'h2008_0005, pc_plus_four=32'h0040_0004, instr_valid=1.
REQ-040 stall_F=1 for 3 cycles while imem_valid arrives: enter HOLD, IF/ID unchanged; on release the held word loads and the next imem_addr is +4.
REQ-041 pc_src=1, jump_address=32'h0040_0100 in WAIT with the response 2 cycles late: enter DRAIN, stale data dropped, next imem_addr=32'h0040_0100, instr_valid=0 for the flush cycle.
REQ-042 pc_src=1 together with stall_F=1: no redirect, pc_F unchanged.
REQ-043 pc_F=32'hFFFF_FFFC fetched: pc_plus_four=32'h0000_0000 and the next imem_addr=0.
REQ-044 reset asserted in WAIT, late imem_valid on the next cycle: ignored; imem_addr=RESET_PC after reset is released.
